bomb_placer: RTL and testbench

- Upstream stage of the game controller: generates the bomb layout that the controller consumes as its `bombGrid`.
- On `start`, it places exactly BOMB_COUNT distinct bombs in free cells of a GRID_SIZE x GRID_SIZE board, using a free-running 8-bit LFSR and rejection sampling.
- Cells flagged in `exclude` are never chosen; the controller uses this for the cursor start cell.
- Handshake: `busy` while placing, then a one-cycle `done` (or `error`) pulse.

---
 rtl/bomb_placer_pkg.sv | 36 +++
 rtl/bomb_placer_if.sv | 20 ++
 rtl/bomb_placer_lfsr8.sv | 30 +++
 rtl/bomb_placer.sv | 123 ++++++++++++
 tb/tb_bomb_placer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_placer_pkg.sv
// Shared constants and helpers for the bomb placer: FSM encodings, LFSR taps,
// index width and the safe-area dilation used when BOMB_PLACER_SAFE_AREA_EN is defined.
package bomb_placer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Marks every cell within one step (8-neighbourhood) of an excluded cell, clipped at the edges.
  function automatic logic [255:0] dilate(input logic [255:0] m, input int gs);
    logic [255:0] d;
    d = '0;
    for (int r = 0; r < gs; r++) begin
      for (int c = 0; c < gs; c++) begin
        if (m[r*gs+c]) begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if ((r + dr >= 0) && (r + dr < gs) && (c + dc >= 0) && (c + dc < gs)) begin
                d[(r+dr)*gs + c + dc] = 1'b1;
              end
            end
          end
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bomb_placer_if.sv
// Request/result bundle between the game controller (master) and the bomb placer (slave).
interface bomb_placer_if #(
  parameter int GRID_SIZE = 3
);
  localparam int N = GRID_SIZE * GRID_SIZE;

  logic         start;
  logic         seed_load;
  logic [7:0]   seed;
  logic [N-1:0] exclude;
  logic [N-1:0] bombGrid;
  logic         busy;
  logic         done;
  logic         error;

  modport master (output start, seed_load, seed, exclude,
                  input  bombGrid, busy, done, error);
  modport slave  (input  start, seed_load, seed, exclude,
                  output bombGrid, busy, done, error);
endinterface

// File: rtl/bomb_placer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with synchronous load; a zero seed is forced to 8'h01
// so the register can never lock up.
module lfsr8
  import bomb_placer_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  output logic [7:0] o_q
);
  localparam logic [7:0] RST_Q = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_q;

  // Load takes priority over the per-cycle step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= RST_Q;
    end else if (i_load) begin
      r_q <= (i_seed == 8'h00) ? 8'h01 : i_seed;
    end else begin
      r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/bomb_placer.sv
// Places BOMB_COUNT distinct bombs on free cells by rejection sampling an LFSR.
// Define BOMB_PLACER_SAFE_AREA_EN to grow each excluded cell to its 8-neighbourhood.
module bomb_placer
  import bomb_placer_pkg::*;
#(
  parameter int         GRID_SIZE  = 3,
  parameter int         BOMB_COUNT = 2,
  parameter logic [7:0] SEED       = DEFAULT_SEED
) (
  input  logic          clock,
  input  logic          reset,
  bomb_placer_if.slave  bus
);
  localparam int N     = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W = idx_w(N);
  localparam int PAD   = 1 << IDX_W;
  localparam int CNT_W = $clog2(N + 1);

  logic [1:0]       r_state;
  logic [N-1:0]     r_mask;
  logic [N-1:0]     r_grid;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic [7:0]       w_q;
  logic [N-1:0]     w_mask;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_avail;
  logic [IDX_W-1:0] w_cand;
  logic [PAD-1:0]   w_taken;
  logic [PAD-1:0]   w_onehot;
  logic             w_accept;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .i_load (bus.seed_load),
    .i_seed (bus.seed),
    .o_q    (w_q)
  );

`ifdef BOMB_PLACER_SAFE_AREA_EN
  logic [255:0] w_dil;
  assign w_dil  = dilate(256'(bus.exclude), GRID_SIZE);
  assign w_mask = N'(w_dil);
`else
  assign w_mask = bus.exclude;
`endif

  // Count free cells; with an 8-bit index the LFSR never yields 0, so cell 0 cannot be drawn.
  always_comb begin
    w_free = '0;
    for (int i = 0; i < N; i++) begin
      w_free = w_free + CNT_W'(!w_mask[i]);
    end
    if ((IDX_W >= 8) && !w_mask[0]) begin
      w_avail = w_free - CNT_W'(1);
    end else begin
      w_avail = w_free;
    end
  end

  assign w_cand   = IDX_W'(w_q);
  assign w_taken  = PAD'(r_mask | r_grid);
  assign w_onehot = {{(PAD-1){1'b0}}, 1'b1} << w_cand;
  assign w_accept = (32'(w_cand) < 32'(N)) && !w_taken[w_cand];

  // Placement FSM: one draw attempt per DRAW cycle, single-cycle done/error pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_grid      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mask <= w_mask;
            if (32'(BOMB_COUNT) > 32'(w_avail)) begin
              r_error <= 1'b1;
            end else begin
              r_grid      <= '0;
              r_remaining <= CNT_W'(BOMB_COUNT);
              r_busy      <= 1'b1;
              r_state     <= ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          if (w_accept) begin
            r_grid      <= r_grid | N'(w_onehot);
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bombGrid = r_grid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
endmodule

// File: tb/tb_bomb_placer.sv
// Bench for bomb_placer: two instances (2 and 8 bombs on a 3x3 board) share stimulus and
// are checked against a loop-based placement model driven by a tracked LFSR value.
module tb_bomb_placer;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       seed_load;
  logic [7:0] seed;
  logic [8:0] exclude;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q;
  logic [8:0] last_grid [2];
  logic [8:0] obs_grid  [2];
  logic       obs_busy  [2];
  logic       obs_done  [2];
  logic       obs_err   [2];

  bomb_placer_if #(.GRID_SIZE(3)) ifa ();
  bomb_placer_if #(.GRID_SIZE(3)) ifb ();

  assign ifa.start = start;  assign ifa.seed_load = seed_load;
  assign ifa.seed  = seed;   assign ifa.exclude   = exclude;
  assign ifb.start = start;  assign ifb.seed_load = seed_load;
  assign ifb.seed  = seed;   assign ifb.exclude   = exclude;

  assign obs_grid[0] = ifa.bombGrid; assign obs_busy[0] = ifa.busy;
  assign obs_done[0] = ifa.done;     assign obs_err[0]  = ifa.error;
  assign obs_grid[1] = ifb.bombGrid; assign obs_busy[1] = ifb.busy;
  assign obs_done[1] = ifb.done;     assign obs_err[1]  = ifb.error;

  bomb_placer #(.GRID_SIZE(3), .BOMB_COUNT(2)) u_a (.clock(clock), .reset(reset), .bus(ifa));
  bomb_placer #(.GRID_SIZE(3), .BOMB_COUNT(8)) u_b (.clock(clock), .reset(reset), .bus(ifb));

  always #5 clock = ~clock;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Reference LFSR value as seen by the DUTs between edges.
  always @(posedge clock) begin
    if (!reset)         m_q <= 8'hA5;
    else if (seed_load) m_q <= (seed == 8'h00) ? 8'h01 : seed;
    else                m_q <= lfsr_next(m_q);
  end

  function automatic void place(input logic [7:0] q0, input logic [8:0] excl, input int cnt,
                                output logic [8:0] grid, output int attempts);
    logic [7:0] q;
    int left;
    int c;
    q = q0; left = cnt; grid = '0; attempts = 0;
    while (left > 0 && attempts < 4096) begin
      c = int'(q[3:0]);
      attempts++;
      if (c < 9 && !excl[c] && !grid[c]) begin
        grid[c] = 1'b1;
        left--;
      end
      q = lfsr_next(q);
    end
  endfunction

  task automatic run(input logic [8:0] excl, input string name);
    int cnt [2];
    logic exp_err [2];
    logic [8:0] eg [2];
    int ek [2];
    int nbusy [2], ndone [2], nerr [2], t_err [2];
    logic fin [2];
    int post, t;
    cnt[0] = 2; cnt[1] = 8;
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = (cnt[d] > 9 - $countones(excl));
      if (exp_err[d]) begin
        eg[d] = last_grid[d];
        ek[d] = 0;
      end else begin
        place(lfsr_next(m_q), excl, cnt[d], eg[d], ek[d]);
      end
      nbusy[d] = 0; ndone[d] = 0; nerr[d] = 0; t_err[d] = -1; fin[d] = 1'b0;
    end
    exclude = excl;
    start   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    post = 0; t = 0;
    while (post < 2 && t < 3000) begin
      for (int d = 0; d < 2; d++) begin
        if (obs_busy[d]) nbusy[d]++;
        if (obs_done[d]) begin ndone[d]++; fin[d] = 1'b1; end
        if (obs_err[d]) begin
          nerr[d]++;
          if (t_err[d] < 0) t_err[d] = t;
          fin[d] = 1'b1;
        end
      end
      if (fin[0] && fin[1]) post++;
      t++;
      @(negedge clock);
    end
    checks++;
    if (!(fin[0] && fin[1])) begin
      failures++;
      $display("FAIL %s timeout: finished a=%0b b=%0b, required both", name, fin[0], fin[1]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_grid[d] !== eg[d]) begin
        failures++;
        $display("FAIL %s dut%0d grid: got %h, required %h", name, d, obs_grid[d], eg[d]);
      end
      checks++;
      if (exp_err[d]) begin
        if (nerr[d] !== 1 || t_err[d] !== 0 || nbusy[d] !== 0 || ndone[d] !== 0) begin
          failures++;
          $display("FAIL %s dut%0d error pulse: err=%0d at t=%0d busy=%0d done=%0d, required 1 at t=0, 0, 0",
                   name, d, nerr[d], t_err[d], nbusy[d], ndone[d]);
        end
      end else begin
        if (ndone[d] !== 1 || nerr[d] !== 0 || nbusy[d] !== ek[d]) begin
          failures++;
          $display("FAIL %s dut%0d completion: done=%0d err=%0d busy_cycles=%0d, required 1, 0, %0d",
                   name, d, ndone[d], nerr[d], nbusy[d], ek[d]);
        end
      end
      last_grid[d] = eg[d];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 8'h00; exclude = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_grid[d] !== 9'h000 || {obs_busy[d], obs_done[d], obs_err[d]} !== 3'b000) begin
        failures++;
        $display("FAIL reset dut%0d: grid=%h busy/done/err=%b, required 000 and 000", d, obs_grid[d],
                 {obs_busy[d], obs_done[d], obs_err[d]});
      end
      last_grid[d] = 9'h000;
    end
    checks++;
    if (u_a.u_lfsr.o_q !== 8'hA5) begin
      failures++;
      $display("FAIL reset lfsr: got %h, required a5", u_a.u_lfsr.o_q);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_seed_zero();
    seed_load = 1'b1; seed = 8'h00;
    @(posedge clock);
    @(negedge clock);
    seed_load = 1'b0;
    checks++;
    if (u_a.u_lfsr.o_q !== 8'h01 || u_b.u_lfsr.o_q !== 8'h01) begin
      failures++;
      $display("FAIL seed_zero: lfsr a=%h b=%h, required 01", u_a.u_lfsr.o_q, u_b.u_lfsr.o_q);
    end
    run(9'h001, "seed1_excl0");
    checks++;
    if (obs_grid[0][0] !== 1'b0 || $countones(obs_grid[0]) !== 2) begin
      failures++;
      $display("FAIL seed1_excl0 shape: grid=%h, required 2 bombs with bit0 clear", obs_grid[0]);
    end
  endtask

  task automatic test_fill();
    run(9'h010, "fill");
    checks++;
    if (obs_grid[1] !== 9'h1EF) begin
      failures++;
      $display("FAIL fill const: got %h, required 1ef", obs_grid[1]);
    end
  endtask

  task automatic test_error();
    run(9'h1FE, "one_free");
  endtask

  task automatic test_random();
    logic [8:0] ex;
    for (int i = 0; i < 10; i++) begin
      seed_load = 1'b1;
      seed = 8'($urandom);
      @(posedge clock);
      @(negedge clock);
      seed_load = 1'b0;
      case ($urandom_range(0, 3))
        0:       ex = 9'h000;
        1:       ex = 9'($urandom & $urandom);
        2:       ex = 9'($urandom);
        default: ex = 9'h1FF ^ (9'h001 << $urandom_range(0, 8));
      endcase
      run(ex, "random");
    end
  endtask

  task automatic test_reset_mid_draw();
    int bad;
    exclude = 9'h000;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_draw busy: got %b, required 1", obs_busy[1]);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      for (int d = 0; d < 2; d++) begin
        if (obs_grid[d] !== 9'h000 || obs_busy[d] || obs_done[d] || obs_err[d]) bad++;
      end
      @(negedge clock);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mid_draw abort: %0d bad samples, required 0", bad);
    end
    last_grid[0] = 9'h000;
    last_grid[1] = 9'h000;
    run(9'h000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_fill();
    test_error();
    test_random();
    test_reset_mid_draw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
